// File: rtl/dcim_pkg.sv
// Shared types and constants for the DCIM global_io sequencer.
package dcim_pkg;

    localparam int NOUT_W    = 51;
    localparam int MAX_IBITS = 16;
    localparam int CNT_W     = 5;

    localparam logic WW_12B = 1'b0;
    localparam logic WW_24B = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        OUT
    } seq_state_e;

    function automatic logic ibits_legal(input logic [CNT_W-1:0] bits);
        return (bits != '0) && (bits <= CNT_W'(MAX_IBITS));
    endfunction

endpackage

// File: rtl/global_io_seq_out.sv
// Result register with valid/ready: captures nout once per MAC and holds it
// until the collector accepts or the operation is aborted.
module global_io_seq_out
    import dcim_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              abort,
    input  logic [NOUT_W-1:0] nout,
    output logic [NOUT_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (capture) begin
            result       <= nout;
            result_valid <= 1'b1;
        end else if (abort || (result_valid && result_ready)) begin
            // abort drops the handshake but leaves the previous result visible
            result_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/global_io_seq.sv
// Sequencer for the global_io shift-accumulator: clear, stream MSB-first
// input-bit cycles, capture nout and hand the result off on valid/ready.
module global_io_seq
    import dcim_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  ibits,
    input  logic              wmode,
    input  logic              abort,
    input  logic              mac_valid,
    input  logic [NOUT_W-1:0] nout,
    output logic              st,
    output logic              acm_en,
    output logic              wwidth,
    output logic [CNT_W-1:0]  bit_idx,
    output logic              busy,
    output logic              err,
    output logic [NOUT_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] bit_idx_d;
    logic             wwidth_d;
    logic             err_d;
    logic             capture;
    logic             launch;
    logic             accum_q;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and infers a latch.
        state_d   = state_q;
        bit_idx_d = bit_idx;
        wwidth_d  = wwidth;
        err_d     = 1'b0;
        capture   = 1'b0;
        launch    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ibits_legal(ibits)) launch = 1'b1;
                    else                    err_d  = 1'b1;
                end
            end
            CLEAR: state_d = ACCUM;
            ACCUM: begin
                if (mac_valid) begin
                    if (bit_idx == '0) state_d   = DRAIN;
                    else               bit_idx_d = bit_idx - CNT_W'(1);
                end
            end
            DRAIN: begin
                capture = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                // start without result_ready is ignored; with it, a legal start chains straight into CLEAR
                if (result_ready) begin
                    state_d = IDLE;
                    if (start) begin
                        if (ibits_legal(ibits)) launch = 1'b1;
                        else                    err_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d   = CLEAR;
            bit_idx_d = ibits - CNT_W'(1);
            wwidth_d  = wmode;
        end

        if (abort) begin
            state_d   = IDLE;
            bit_idx_d = bit_idx;
            wwidth_d  = wwidth;
            err_d     = 1'b0;
            capture   = 1'b0;
        end
    end

    // Control outputs are decoded from the next state so they are registered yet valid in the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bit_idx <= '0;
            wwidth  <= WW_12B;
            err     <= 1'b0;
            st      <= 1'b1;
            busy    <= 1'b0;
            accum_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values regardless of statement order.
            state_q <= state_d;
            bit_idx <= bit_idx_d;
            wwidth  <= wwidth_d;
            err     <= err_d;
            st      <= (state_d == IDLE) || (state_d == CLEAR);
            busy    <= (state_d != IDLE);
            accum_q <= (state_d == ACCUM);
        end
    end

    // global_io registers acm_en itself, so it accumulates on the very edge that closes a valid ACCUM cycle.
    assign acm_en = accum_q & mac_valid & ~abort;

    global_io_seq_out u_out (
        .clk          (clk),
        .rst          (rst),
        .capture      (capture),
        .abort        (abort),
        .nout         (nout),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

endmodule
